// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N-to-1 mux arbiter; define ARB_LOCK_EN to add req_lock burst hold
module rr_mux_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_sel,
    output logic [NUM_REQ-1:0]            grant
);
    localparam int SW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state;
    logic [SW-1:0] ptr, nxt_ptr, scan_start, pick;
    logic [NUM_REQ-1:0] scan_mask;
    logic found, hs, lock_hold;
    assign out_valid  = state == GRANT;
    assign hs         = out_valid && out_ready;
    assign req_ready  = hs ? grant : {NUM_REQ{1'b0}};
    assign out_data   = req_data[int'(out_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign nxt_ptr    = (out_sel == SW'(NUM_REQ-1)) ? {SW{1'b0}} : out_sel + SW'(1);
    assign scan_start = out_valid ? nxt_ptr : ptr;
    assign scan_mask  = req_valid & ~(out_valid ? grant : {NUM_REQ{1'b0}});
`ifdef ARB_LOCK_EN
    assign lock_hold = req_lock[out_sel];
`else
    assign lock_hold = 1'b0;
`endif
    always_comb begin
        found = 1'b0;
        pick  = {SW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && scan_mask[(int'(scan_start) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = SW'((int'(scan_start) + k) % NUM_REQ);
            end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= {SW{1'b0}};
            out_sel <= {SW{1'b0}};
            grant   <= {NUM_REQ{1'b0}};
        end else if (!out_valid) begin
            if (found) begin
                state   <= GRANT;
                out_sel <= pick;
                grant   <= NUM_REQ'(1) << pick;
            end
        end else if (hs && !lock_hold) begin
            ptr <= nxt_ptr;
            if (found) begin
                out_sel <= pick;
                grant   <= NUM_REQ'(1) << pick;
            end else begin
                state <= IDLE;
                grant <= {NUM_REQ{1'b0}};
            end
        end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one datapath slot among NUM_REQ requesters.
- Drives the select of a flat N-to-1 data mux and presents the selected word on a single valid/ready output port.
- Used where several pipeline sources compete for one consumer, e.g. write-back or memory-request sharing.
- Grant is held until the output handshake completes, then the pointer rotates.

Parameters:
- DATA_WIDTH, 32: width of each requester's data word.
- NUM_REQ, 4: number of requesters; must be >= 2; need not be a power of 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester valid; bit i belongs to requester i.
- req_data  in  DATA_WIDTH*NUM_REQ  flat requester data; requester i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- out_valid  out  1  selected word valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH  selected requester's data slice.
- out_sel  out  $clog2(NUM_REQ)  index of the granted requester.
- grant  out  NUM_REQ  one-hot grant; all zero when idle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ptr=0, out_sel=0, grant=0.
  - out_valid=0, req_ready=0.
  - out_data = slice 0 (combinational from out_sel).
  - Reset mid-grant drops the pending transfer. No req_ready pulse occurs.
- States: IDLE, GRANT.
- Round-robin pick:
  - Take the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - Index NUM_REQ-1 wraps to 0.
- IDLE:
  - If any req_valid is high, register the pick into out_sel/grant and go to GRANT next cycle.
  - Latency from request to out_valid is 1 cycle.
- GRANT:
  - out_valid=1.
  - out_data = req_data slice[out_sel], combinational.
  - req_ready[out_sel]=out_ready; all other req_ready bits are 0.
  - While out_ready=0: out_sel, grant and ptr hold. New requests are ignored.
  - On handshake (out_valid & out_ready): ptr <= out_sel+1 (wrapping).
    - Pick again from that pointer over req_valid, excluding out_sel.
    - If a pick exists, stay in GRANT with the new out_sel next cycle (back-to-back, 1 word/cycle).
    - Otherwise go to IDLE, with grant=0 and out_valid=0.
- A sole streaming requester is therefore served at 1 word per 2 cycles. Two or more active requesters get full throughput.
- Requester protocol:
  - Once req_valid[i] is high, it and its data must hold until req_ready[i].
  - Dropping valid while granted is a protocol violation. The arbiter does not check it; the bench asserts it.
- out_sel and grant are registered outputs. out_data, out_valid and req_ready are combinational from state/out_sel.
- Invariants:
  - grant is one-hot or zero.
  - grant[out_sel]=1 whenever out_valid=1.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro:
  - Adds input req_lock [NUM_REQ].
  - At a handshake where req_lock[out_sel]=1, the grant stays with out_sel: no re-arbitration, ptr unchanged, state stays GRANT. This gives back-to-back bursts.
  - The lock releases at the first handshake with req_lock[out_sel]=0, then normal rotation applies.
- Without the macro: the port is absent and every handshake rotates as above.

Test Plan:
- Reset: assert rst_n=0 mid-grant with req_valid=4'b1111 -> out_valid=0, grant=0, req_ready=0, out_sel=0 immediately. First grant after release is requester 0.
- Single request: req_valid=4'b0100, slice2=0xDEADBEEF, out_ready=1.
  - Next cycle: out_valid=1, out_sel=2, grant=4'b0100, out_data=0xDEADBEEF, req_ready=4'b0100.
  - Following cycle (req dropped): IDLE, out_valid=0.
- Rotation: req_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1, one handshake per cycle after the first grant.
- Backpressure: grant on 1, req_valid=4'b0011, out_ready=0 for 5 cycles.
  - During those cycles: out_sel=1, out_data stable, req_ready=0.
  - Raise out_ready: req_ready=4'b0010 that cycle, next grant 0.
- Wrap/exclusion:
  - After granting 3 with req_valid=4'b1001 -> next grant is 0.
  - Sole requester 1 streaming -> out_valid toggles 1,0,1,0.
- Lock (ARB_LOCK_EN): req_valid=4'b0110, req_lock[1]=1 for 3 beats, then 0 -> out_sel 1,1,1,1 for 4 beats, then 2.
